eth_rx_axis_packer: RTL and testbench

//  RGMII receive-side framer: converts IDDR-captured RGMII nibbles (1G DDR or 10/100 SDR) into
//  a parametrised-width AXI-Stream. Strips preamble/SFD, packs bytes little-endian, flags
//  PHY/nibble errors and buffer overflow in tuser, and absorbs backpressure in an internal FIFO.

---
 rtl/eth_rx_pkg.sv | 26 ++
 rtl/eth_rx_sync_fifo.sv | 59 +++++
 rtl/eth_rx_axis_packer.sv | 262 ++++++++++++++++++++++++++
 tb/tb_eth_rx_axis_packer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_rx_pkg.sv
// rtl/eth_rx_pkg.sv - shared types and constants for the RGMII receive packer
package eth_rx_pkg;

    typedef enum logic [1:0] {
        SPEED_1G   = 2'b00,
        SPEED_100M = 2'b01,
        SPEED_10M  = 2'b10
    } link_speed_e;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        DATA,
        DISCARD,
        DROP,
        TERM
    } rx_state_e;

    localparam logic [7:0] ETH_PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] ETH_SFD_BYTE      = 8'hD5;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/eth_rx_sync_fifo.sv
// rtl/eth_rx_sync_fifo.sv - single-clock first-word-fall-through FIFO
module eth_rx_sync_fifo #(
    parameter int WIDTH = 38,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    input  logic             rd_en
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign rd_valid = (count != '0);
    assign do_rd    = rd_en && rd_valid;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts a write.
    assign wr_ready = (count != FULL_CNT) || do_rd;
    assign do_wr    = wr_en && wr_ready;
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_wr && !do_rd) begin
                count <= count + (AW+1)'(1);
            end else if (do_rd && !do_wr) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/eth_rx_axis_packer.sv
// rtl/eth_rx_axis_packer.sv - RGMII receive framer packing bytes into an AXI-Stream
// Optional frame statistics outputs are enabled by ETH_RX_STATS_EN.
module eth_rx_axis_packer
    import eth_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                    clk_125,
    input  logic                    reset,
    input  logic [1:0]              link_speed,
    input  logic                    rx_ce,
    input  logic [3:0]              rxd_rise,
    input  logic [3:0]              rxd_fall,
    input  logic                    rx_ctl_rise,
    input  logic                    rx_ctl_fall,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tuser
`ifdef ETH_RX_STATS_EN
    ,
    output logic [31:0]             stat_frames_ok,
    output logic [31:0]             stat_frames_bad,
    output logic [31:0]             stat_frames_dropped
`endif
);

    localparam int KEEP_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_W      = $clog2(KEEP_WIDTH + 1);
    localparam int FIFO_W     = DATA_WIDTH + KEEP_WIDTH + 2;

    logic                  is_1g;
    logic                  smp_dv;
    logic                  smp_er;
    logic                  nib_phase;
    logic [3:0]            nib_lo;
    logic                  dv_q;
    logic                  cur_dv;
    logic                  byte_stb;
    logic                  dv_low;
    logic                  er_stb;
    logic [7:0]            rx_byte;

    rx_state_e             state;
    logic [DATA_WIDTH-1:0] pack_data;
    logic [DATA_WIDTH-1:0] pack_next;
    logic [CNT_W-1:0]      pack_cnt;
    logic [KEEP_WIDTH-1:0] part_keep;
    logic [DATA_WIDTH-1:0] pend_data;
    logic                  pend_valid;
    logic                  frame_er;
    logic                  frame_bad;

    logic                  push_req;
    logic [DATA_WIDTH-1:0] push_data;
    logic [KEEP_WIDTH-1:0] push_keep;
    logic                  push_last;
    logic                  push_user;
    logic                  fifo_wr_ready;
    logic                  drop_now;
    logic [FIFO_W-1:0]     fifo_rd_data;

    assign is_1g    = (link_speed == SPEED_1G);
    assign smp_dv   = rx_ctl_rise;
    assign smp_er   = rx_ctl_rise ^ rx_ctl_fall;
    assign byte_stb = rx_ce && smp_dv && (is_1g || nib_phase);
    assign dv_low   = rx_ce && !smp_dv;
    assign er_stb   = rx_ce && smp_dv && smp_er;
    assign rx_byte  = is_1g ? {rxd_fall, rxd_rise} : {rxd_rise, nib_lo};
    assign cur_dv   = rx_ce ? smp_dv : dv_q;

    // 10/100 nibble pairing: low nibble arrives first, phase restarts whenever DV drops.
    always_ff @(posedge clk_125 or posedge reset) begin
        if (reset) begin
            nib_phase <= 1'b0;
            nib_lo    <= '0;
            dv_q      <= 1'b0;
        end else if (rx_ce) begin
            dv_q <= smp_dv;
            if (!smp_dv || is_1g) begin
                nib_phase <= 1'b0;
            end else begin
                nib_phase <= !nib_phase;
                if (!nib_phase) begin
                    nib_lo <= rxd_rise;
                end
            end
        end
    end

    always_comb begin
        pack_next = pack_data;
        pack_next[{pack_cnt, 3'b000} +: 8] = rx_byte;
        part_keep = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            part_keep[i] = (CNT_W'(i) < pack_cnt);
        end
    end

    // A trailing unpaired nibble at 10/100 marks the frame bad.
    assign frame_bad = frame_er || (!is_1g && nib_phase);

    always_comb begin
        push_req  = 1'b0;
        push_data = pend_data;
        push_keep = '1;
        push_last = 1'b0;
        push_user = 1'b0;
        case (state)
            DATA: begin
                if (byte_stb && pend_valid) begin
                    push_req = 1'b1;
                end else if (dv_low) begin
                    if (pend_valid) begin
                        push_req  = 1'b1;
                        push_last = 1'b1;
                        push_user = frame_bad;
                    end else if (pack_cnt != '0) begin
                        push_req  = 1'b1;
                        push_data = pack_data;
                        push_keep = part_keep;
                        push_last = 1'b1;
                        push_user = frame_bad;
                    end
                end
            end
            TERM: begin
                push_req  = 1'b1;
                push_data = '0;
                push_keep = '0;
                push_last = 1'b1;
                push_user = 1'b1;
            end
            default: begin
                push_req = 1'b0;
            end
        endcase
    end

    assign drop_now = (state == DATA) && push_req && !fifo_wr_ready;

    always_ff @(posedge clk_125 or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pack_data  <= '0;
            pack_cnt   <= '0;
            pend_data  <= '0;
            pend_valid <= 1'b0;
            frame_er   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (byte_stb) begin
                        state <= (rx_byte == ETH_PREAMBLE_BYTE) ? PREAMBLE : DISCARD;
                    end
                end
                PREAMBLE: begin
                    if (dv_low) begin
                        state <= IDLE;
                    end else if (byte_stb) begin
                        if (rx_byte == ETH_SFD_BYTE) begin
                            state      <= DATA;
                            pack_data  <= '0;
                            pack_cnt   <= '0;
                            pend_valid <= 1'b0;
                            frame_er   <= 1'b0;
                        end else if (rx_byte != ETH_PREAMBLE_BYTE) begin
                            state <= DISCARD;
                        end
                    end
                end
                DATA: begin
                    if (er_stb) begin
                        frame_er <= 1'b1;
                    end
                    if (drop_now || dv_low) begin
                        state      <= drop_now ? DROP : IDLE;
                        pack_data  <= '0;
                        pack_cnt   <= '0;
                        pend_valid <= 1'b0;
                    end else if (byte_stb) begin
                        if (pack_cnt == CNT_W'(KEEP_WIDTH - 1)) begin
                            pend_data  <= pack_next;
                            pend_valid <= 1'b1;
                            pack_data  <= '0;
                            pack_cnt   <= '0;
                        end else begin
                            pack_data  <= pack_next;
                            pack_cnt   <= pack_cnt + CNT_W'(1);
                            pend_valid <= 1'b0;
                        end
                    end
                end
                DISCARD: begin
                    if (dv_low) begin
                        state <= IDLE;
                    end
                end
                DROP: begin
                    if (dv_low) begin
                        state <= TERM;
                    end
                end
                TERM: begin
                    if (fifo_wr_ready) begin
                        state <= cur_dv ? DISCARD : IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    eth_rx_sync_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk_125),
        .reset    (reset),
        .wr_en    (push_req),
        .wr_data  ({push_user, push_last, push_keep, push_data}),
        .wr_ready (fifo_wr_ready),
        .rd_valid (m_axis_tvalid),
        .rd_data  (fifo_rd_data),
        .rd_en    (m_axis_tready)
    );

    assign m_axis_tdata = fifo_rd_data[DATA_WIDTH-1:0];
    assign m_axis_tkeep = fifo_rd_data[DATA_WIDTH +: KEEP_WIDTH];
    assign m_axis_tlast = fifo_rd_data[FIFO_W-2];
    assign m_axis_tuser = fifo_rd_data[FIFO_W-1];

`ifdef ETH_RX_STATS_EN
    logic fifo_wr;
    assign fifo_wr = push_req && fifo_wr_ready;

    always_ff @(posedge clk_125 or posedge reset) begin
        if (reset) begin
            stat_frames_ok      <= '0;
            stat_frames_bad     <= '0;
            stat_frames_dropped <= '0;
        end else begin
            if (fifo_wr && push_last) begin
                if (push_user) begin
                    stat_frames_bad <= sat_inc(stat_frames_bad);
                end else begin
                    stat_frames_ok <= sat_inc(stat_frames_ok);
                end
            end
            if (drop_now) begin
                stat_frames_dropped <= sat_inc(stat_frames_dropped);
            end
        end
    end
`endif

endmodule

// File: tb/tb_eth_rx_axis_packer.sv
// tb/tb_eth_rx_axis_packer.sv - directed vector bench for eth_rx_axis_packer
module tb_eth_rx_axis_packer;

    localparam int DW = 32;
    localparam int KW = 4;

    logic          clk_125 = 1'b0;
    logic          reset;
    logic [1:0]    spd;
    logic          rx_ce;
    logic [3:0]    rxd_rise;
    logic [3:0]    rxd_fall;
    logic          rx_ctl_rise;
    logic          rx_ctl_fall;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic          m_axis_tuser;
`ifdef ETH_RX_STATS_EN
    logic [31:0]   stat_ok;
    logic [31:0]   stat_bad;
    logic [31:0]   stat_drop;
`endif

    always #4 clk_125 = ~clk_125;

    eth_rx_axis_packer #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_125       (clk_125),
        .reset         (reset),
        .link_speed    (spd),
        .rx_ce         (rx_ce),
        .rxd_rise      (rxd_rise),
        .rxd_fall      (rxd_fall),
        .rx_ctl_rise   (rx_ctl_rise),
        .rx_ctl_fall   (rx_ctl_fall),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser)
`ifdef ETH_RX_STATS_EN
        ,
        .stat_frames_ok      (stat_ok),
        .stat_frames_bad     (stat_bad),
        .stat_frames_dropped (stat_drop)
`endif
    );

    typedef struct {
        logic [1:0]  speed;
        int          nbytes;
        logic [7:0]  start;
        int          er_idx;
        bit          odd_nib;
        bit          bad_pre;
        int          exp_words;
        logic [31:0] exp_last_data;
        logic [3:0]  exp_last_keep;
        bit          exp_user;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic        user;
    } beat_t;

    beat_t got_q[$];
    vec_t  vecs[10];
    int    checks = 0;
    int    errors = 0;
    int    div = 1;
    int    exp_ok = 0;
    int    exp_bad = 0;

    always @(negedge clk_125) begin
        if (m_axis_tvalid && m_axis_tready) begin
            got_q.push_back('{m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser});
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic sample(input logic [3:0] lo, input logic [3:0] hi, input logic dv, input logic er);
        @(posedge clk_125); #1;
        rx_ce       = 1'b1;
        rxd_rise    = lo;
        rxd_fall    = hi;
        rx_ctl_rise = dv;
        rx_ctl_fall = dv ^ er;
        if (spd != 2'b00) begin
            for (int k = 1; k < div; k++) begin
                @(posedge clk_125); #1;
                rx_ce = 1'b0;
            end
        end
    endtask

    task automatic put_byte(input logic [7:0] b, input logic dv, input logic er);
        if (spd == 2'b00) begin
            sample(b[3:0], b[7:4], dv, er);
        end else begin
            sample(b[3:0], 4'h0, dv, er);
            sample(b[7:4], 4'h0, dv, er);
        end
    endtask

    task automatic send_frame(input vec_t v);
        spd = v.speed;
        div = (v.speed == 2'b01) ? 5 : 10;
        for (int i = 0; i < 7; i++) begin
            put_byte((v.bad_pre && i == 6) ? 8'h5D : 8'h55, 1'b1, 1'b0);
        end
        put_byte(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < v.nbytes; i++) begin
            put_byte(v.start + 8'(i), 1'b1, i == v.er_idx);
        end
        if (v.odd_nib) begin
            sample(4'h7, 4'h0, 1'b1, 1'b0);
        end
        for (int i = 0; i < 12; i++) begin
            put_byte(8'h00, 1'b0, 1'b0);
        end
    endtask

    function automatic logic [31:0] model_word(input vec_t v, input int w);
        logic [31:0] d;
        d = '0;
        for (int b = 0; b < 4; b++) begin
            if (w * 4 + b < v.nbytes) begin
                d[b*8 +: 8] = v.start + 8'(w * 4 + b);
            end
        end
        return d;
    endfunction

    task automatic check_frame(input vec_t v, input string tag);
        int n;
        chk({tag, " words"}, 32'(got_q.size()), 32'(v.exp_words));
        n = (got_q.size() < v.exp_words) ? got_q.size() : v.exp_words;
        for (int w = 0; w < n; w++) begin
            if (w == v.exp_words - 1) begin
                chk($sformatf("%s w%0d data", tag, w), got_q[w].data, v.exp_last_data);
                chk($sformatf("%s w%0d keep", tag, w), 32'(got_q[w].keep), 32'(v.exp_last_keep));
                chk($sformatf("%s w%0d tlast", tag, w), 32'(got_q[w].last), 32'd1);
                chk($sformatf("%s w%0d tuser", tag, w), 32'(got_q[w].user), 32'(v.exp_user));
            end else begin
                chk($sformatf("%s w%0d data", tag, w), got_q[w].data, model_word(v, w));
                chk($sformatf("%s w%0d keep", tag, w), 32'(got_q[w].keep), 32'hF);
                chk($sformatf("%s w%0d tlast", tag, w), 32'(got_q[w].last), 32'd0);
            end
        end
    endtask

    initial begin
        vec_t vb;
        vec_t vo;
        vec_t vg;

        //            speed  n   start  er  odd bad words last_data      keep  user
        vecs[0] = '{2'b00, 8, 8'h01, -1, 1'b0, 1'b0, 2, 32'h08070605, 4'hF, 1'b0};
        vecs[1] = '{2'b00, 5, 8'h11, -1, 1'b0, 1'b0, 2, 32'h00000015, 4'h1, 1'b0};
        vecs[2] = '{2'b01, 4, 8'hA1, -1, 1'b1, 1'b0, 1, 32'hA4A3A2A1, 4'hF, 1'b1};
        vecs[3] = '{2'b00, 8, 8'h31,  2, 1'b0, 1'b0, 2, 32'h38373635, 4'hF, 1'b1};
        vecs[4] = '{2'b10, 6, 8'h41, -1, 1'b0, 1'b0, 2, 32'h00004645, 4'h3, 1'b0};
        vecs[5] = '{2'b00, 1, 8'h51, -1, 1'b0, 1'b0, 1, 32'h00000051, 4'h1, 1'b0};
        vecs[6] = '{2'b00, 0, 8'h00, -1, 1'b0, 1'b0, 0, 32'h00000000, 4'h0, 1'b0};
        vecs[7] = '{2'b00, 8, 8'h61, -1, 1'b0, 1'b1, 0, 32'h00000000, 4'h0, 1'b0};
        vecs[8] = '{2'b00, 7, 8'h71, -1, 1'b0, 1'b0, 2, 32'h00777675, 4'h7, 1'b0};
        vecs[9] = '{2'b01, 3, 8'h81, -1, 1'b0, 1'b0, 1, 32'h00838281, 4'h7, 1'b0};
        vb = '{2'b00, 12, 8'hC1, -1, 1'b0, 1'b0, 3, 32'hCCCBCAC9, 4'hF, 1'b0};
        vo = '{2'b00, 64, 8'h01, -1, 1'b0, 1'b0, 5, 32'h00000000, 4'h0, 1'b1};
        vg = '{2'b00, 4, 8'hE1, -1, 1'b0, 1'b0, 1, 32'hE4E3E2E1, 4'hF, 1'b0};

        reset = 1'b1;
        spd = 2'b00;
        rx_ce = 1'b1;
        rxd_rise = '0;
        rxd_fall = '0;
        rx_ctl_rise = 1'b0;
        rx_ctl_fall = 1'b0;
        m_axis_tready = 1'b1;
        repeat (3) @(posedge clk_125);
        #1;
        chk("reset tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("reset tdata", m_axis_tdata, 32'd0);
        chk("reset tkeep", 32'(m_axis_tkeep), 32'd0);
        chk("reset tlast", 32'(m_axis_tlast), 32'd0);
        chk("reset tuser", 32'(m_axis_tuser), 32'd0);
`ifdef ETH_RX_STATS_EN
        chk("reset stat_ok", stat_ok, 32'd0);
        chk("reset stat_drop", stat_drop, 32'd0);
`endif
        reset = 1'b0;
        repeat (4) @(posedge clk_125);

        for (int i = 0; i < 10; i++) begin
            got_q.delete();
            send_frame(vecs[i]);
            repeat (10) @(posedge clk_125);
            check_frame(vecs[i], $sformatf("vec%0d", i));
            if (vecs[i].exp_words > 0) begin
                if (vecs[i].exp_user) exp_bad++;
                else exp_ok++;
            end
        end

        // Random backpressure while a frame streams in.
        got_q.delete();
        fork
            send_frame(vb);
            begin
                repeat (150) begin
                    @(posedge clk_125); #1;
                    m_axis_tready = 1'($urandom_range(0, 1));
                end
                m_axis_tready = 1'b1;
            end
        join
        repeat (10) @(posedge clk_125);
        check_frame(vb, "backpressure");
        exp_ok++;

        // Overflow: FIFO fills, frame is truncated with a terminator word.
        @(posedge clk_125); #1;
        m_axis_tready = 1'b0;
        got_q.delete();
        send_frame(vo);
        repeat (5) @(posedge clk_125);
        chk("overflow stalled words", 32'(got_q.size()), 32'd0);
        #1;
        m_axis_tready = 1'b1;
        repeat (12) @(posedge clk_125);
        check_frame(vo, "overflow");
        exp_bad++;
`ifdef ETH_RX_STATS_EN
        chk("stat_ok", stat_ok, 32'(exp_ok));
        chk("stat_bad", stat_bad, 32'(exp_bad));
        chk("stat_drop", stat_drop, 32'd1);
`endif

        // Reset in the middle of a frame with words queued.
        @(posedge clk_125); #1;
        m_axis_tready = 1'b0;
        spd = 2'b00;
        for (int i = 0; i < 7; i++) put_byte(8'h55, 1'b1, 1'b0);
        put_byte(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) put_byte(8'hD1 + 8'(i), 1'b1, 1'b0);
        @(posedge clk_125); #1;
        chk("midreset queued tvalid", 32'(m_axis_tvalid), 32'd1);
        reset = 1'b1;
        #1;
        chk("midreset tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("midreset tdata", m_axis_tdata, 32'd0);
`ifdef ETH_RX_STATS_EN
        chk("midreset stat_ok", stat_ok, 32'd0);
        chk("midreset stat_bad", stat_bad, 32'd0);
`endif
        @(posedge clk_125); #1;
        reset = 1'b0;
        m_axis_tready = 1'b1;
        got_q.delete();
        for (int i = 0; i < 6; i++) put_byte(8'hDB + 8'(i), 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) put_byte(8'h00, 1'b0, 1'b0);
        repeat (10) @(posedge clk_125);
        chk("midreset tail words", 32'(got_q.size()), 32'd0);
        got_q.delete();
        send_frame(vg);
        repeat (10) @(posedge clk_125);
        check_frame(vg, "after reset");
`ifdef ETH_RX_STATS_EN
        chk("after reset stat_ok", stat_ok, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
